bypass_scoreboard: RTL
======================

// Module: bypass_scoreboard
// PURPOSE
// - Parametrised operand-bypass and hazard unit for the in-order integer pipeline.
// - Tracks every in-flight register write from decode through writeback in a shift register.
// - Forwards the youngest ready result to NREAD decode read ports and raises a stall when that result is not yet ready.
// - Produces the register-file write port from the oldest tracked stage.
// - Replaces the hard-coded 3-deep, 2-port bypass muxes inside the datapath.
// PARAMETERS
// XLEN     32  data width
// AW       5   register address width; register 0 is hard zero
// NSTAGES  3   tracked stages after decode (0=EX, 1=MEM, ..., NSTAGES-1=WB); must be >= 2
// NREAD    2   decode read ports
// PORTS
// clk        in   1            clock
// rst_n      in   1            synchronous active-low reset
// freeze     in   1            cache-miss stall: hold every entry
// flush      in   1            pipeline kill: drop every entry
// dec_valid  in   1            decode holds a real instruction
// dec_kill   in   1            squash the decode instruction (branch or jump)
// dec_wen    in   1            decode instruction writes rd
// dec_waddr  in   AW           rd of the decode instruction
// dec_rdy    in   $clog2(NSTAGES)  first stage whose stage_data carries the result (0=ALU, 1=load)
// rs_addr    in   NREAD*AW     source addresses; port p at [p*AW +: AW]
// rs_used    in   NREAD        port p is actually read by the decode instruction
// rf_rdata   in   NREAD*XLEN   register-file read data, one word per port
// stage_data in   NSTAGES*XLEN result currently presented by each stage
// op_data    out  NREAD*XLEN   bypassed operand, one word per port
// fwd_hit    out  NREAD        port p took its data from a stage rather than rf_rdata
// hazard     out  1            decode must stall this cycle
// rf_we      out  1            register-file write enable
// rf_waddr   out  AW           register-file write address
// rf_wdata   out  XLEN         register-file write data (= stage_data[NSTAGES-1])
// BEHAVIOUR
// - State is entry e[s] = {valid, wen, waddr, rdy} for s = 0..NSTAGES-1.
// - Reset: all e[s].valid = 0, so hazard=0, rf_we=0, fwd_hit=0 and op_data=rf_rdata (zero for addr 0).
// - Clock-edge update, priority flush > freeze > advance:
//   - flush: every e[s].valid <= 0, including when freeze is also set.
//   - freeze: all entries hold.
//   - advance: e[s+1] <= e[s]; e[0] <= {dec_valid & !dec_kill & !hazard, dec_wen & (dec_waddr!=0), dec_waddr, dec_rdy}.
//   - A stalled (hazard) or killed instruction enters EX as a bubble.
// - Match on port p at stage s: e[s].valid & e[s].wen & e[s].waddr==rs_addr[p] & rs_addr[p]!=0.
// - Selection: the lowest s with a match wins (youngest producer).
//   - If s >= e[s].rdy: op_data[p]=stage_data[s] and fwd_hit[p]=1.
//   - Otherwise: port p is not-ready.
//   - No match: op_data[p]=rf_rdata[p] and fwd_hit[p]=0. rs_addr[p]==0 forces op_data[p]=0.
// - hazard = dec_valid & !dec_kill & OR over p of (rs_used[p] & port p not-ready).
//   - Fully combinational, 0-cycle latency.
//   - Independent of freeze; the control unit ORs it into dec_stall.
// - dec_rdy >= NSTAGES is treated as NSTAGES-1.
// - Write port: rf_we = e[NSTAGES-1].valid & e[NSTAGES-1].wen & !freeze; rf_waddr = e[NSTAGES-1].waddr.
//   - The WB entry always forwards, so the register file needs no write-through.
// - Reset asserted mid-operation clears all entries at the next edge, regardless of freeze and flush.
// STRUCTURE
// - Bundle package gets:
//   - typedef BypassEntry {valid, wen, waddr, rdy}
//   - localparams RDY_EX=0, RDY_MEM=1
// - One sub-module, bypass_select: priority match and mux for one read port, instantiated NREAD times in a generate loop.
// - The entry shift register and the hazard OR stay in the top.
// TESTING
// - ALU chain: issue x5 with rdy=0; next cycle read x5 with stage_data[0]=0x11 -> op_data=0x11, fwd_hit=1, hazard=0.
// - Load-use: issue load x7 with rdy=1; next cycle read x7 -> hazard=1 and a bubble enters EX.
//   - Following cycle, stage_data[1]=0xCAFE -> op_data=0xCAFE, hazard=0.
// - Priority: x3 in EX (0xAA) and in WB (0xBB) -> op_data=0xAA; rf_we=1, rf_waddr=3, rf_wdata=0xBB.
// - x0 and unused port: write x0 then read x0 -> op_data=0, rf_we=0 when it reaches WB.
//   - Pending load on x9 with rs_used=0 -> hazard=0.
// - freeze held 3 cycles: entries and rf_we=0 hold, then resume in order.
//   - flush together with freeze -> all entries invalid at the next edge; op_data=rf_rdata.
// - Reset pulse with 3 valid entries -> the next cycle shows hazard=0, rf_we=0, fwd_hit=0.
//   - Repeat with NSTAGES=4, NREAD=3 and a rdy=2 producer -> hazard for 2 cycles.

Source files
------------

// File: rtl/bypass_scoreboard_pkg.sv
// Shared types and constants for the operand-bypass scoreboard.
package bypass_scoreboard_pkg;

  localparam int unsigned RDY_EX  = 0;
  localparam int unsigned RDY_MEM = 1;

  // Storage widths for an entry; AW <= ENTRY_AW and NSTAGES <= 2**ENTRY_RW.
  localparam int unsigned ENTRY_AW = 8;
  localparam int unsigned ENTRY_RW = 4;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [ENTRY_AW-1:0] waddr;
    logic [ENTRY_RW-1:0] rdy;
  } bypass_entry_t;

endpackage

// File: rtl/bypass_select.sv
// Priority match and operand mux for one decode read port.
module bypass_select
  import bypass_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NSTAGES = 3
) (
  input  bypass_entry_t             entries_i [NSTAGES],
  input  logic [AW-1:0]             rs_addr_i,
  input  logic [XLEN-1:0]           rf_rdata_i,
  input  logic [NSTAGES*XLEN-1:0]   stage_data_i,
  output logic [XLEN-1:0]           op_data_o,
  output logic                      fwd_hit_o,
  output logic                      not_ready_o
);

  logic [ENTRY_AW-1:0] rs_addr_ext;
  logic                found;

  assign rs_addr_ext = ENTRY_AW'(rs_addr_i);

  always_comb begin
    op_data_o   = rf_rdata_i;
    fwd_hit_o   = 1'b0;
    not_ready_o = 1'b0;
    found       = 1'b0;
    // Lowest stage index is the youngest producer, so it wins.
    for (int s = 0; s < int'(NSTAGES); s++) begin
      if (!found && entries_i[s].valid && entries_i[s].wen &&
          (entries_i[s].waddr == rs_addr_ext) && (rs_addr_i != '0)) begin
        found = 1'b1;
        if (s >= int'(entries_i[s].rdy)) begin
          op_data_o = stage_data_i[s*XLEN +: XLEN];
          fwd_hit_o = 1'b1;
        end else begin
          not_ready_o = 1'b1;
        end
      end
    end
    if (rs_addr_i == '0) begin
      op_data_o = '0;
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// In-flight write tracker: forwards stage results to decode, raises load-use stalls,
// and drives the register-file write port from the oldest tracked stage.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned NREAD   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        freeze_i,
  input  logic                        flush_i,
  input  logic                        dec_valid_i,
  input  logic                        dec_kill_i,
  input  logic                        dec_wen_i,
  input  logic [AW-1:0]               dec_waddr_i,
  input  logic [$clog2(NSTAGES)-1:0]  dec_rdy_i,
  input  logic [NREAD*AW-1:0]         rs_addr_i,
  input  logic [NREAD-1:0]            rs_used_i,
  input  logic [NREAD*XLEN-1:0]       rf_rdata_i,
  input  logic [NSTAGES*XLEN-1:0]     stage_data_i,
  output logic [NREAD*XLEN-1:0]       op_data_o,
  output logic [NREAD-1:0]            fwd_hit_o,
  output logic                        hazard_o,
  output logic                        rf_we_o,
  output logic [AW-1:0]               rf_waddr_o,
  output logic [XLEN-1:0]             rf_wdata_o
);

  bypass_entry_t       entry_q [NSTAGES];
  bypass_entry_t       entry_d [NSTAGES];
  logic [NREAD-1:0]    not_ready;
  logic [ENTRY_RW-1:0] dec_rdy_clamped;

  always_comb begin
    if (int'(dec_rdy_i) >= int'(NSTAGES)) begin
      dec_rdy_clamped = ENTRY_RW'(NSTAGES - 1);
    end else begin
      dec_rdy_clamped = ENTRY_RW'(dec_rdy_i);
    end
  end

  always_comb begin
    for (int s = 0; s < int'(NSTAGES); s++) begin
      entry_d[s] = entry_q[s];
    end
    if (flush_i) begin
      for (int s = 0; s < int'(NSTAGES); s++) begin
        entry_d[s] = '0;
      end
    end else if (!freeze_i) begin
      for (int s = int'(NSTAGES) - 1; s > 0; s--) begin
        entry_d[s] = entry_q[s-1];
      end
      // Stalled or killed decode instructions enter EX as a bubble.
      entry_d[0].valid = dec_valid_i & ~dec_kill_i & ~hazard_o;
      entry_d[0].wen   = dec_wen_i & (dec_waddr_i != '0);
      entry_d[0].waddr = ENTRY_AW'(dec_waddr_i);
      entry_d[0].rdy   = dec_rdy_clamped;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(NSTAGES); s++) begin
        entry_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < int'(NSTAGES); s++) begin
        entry_q[s] <= entry_d[s];
      end
    end
  end

  for (genvar p = 0; p < int'(NREAD); p++) begin : g_port
    bypass_select #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NSTAGES (NSTAGES)
    ) u_select (
      .entries_i    (entry_q),
      .rs_addr_i    (rs_addr_i[p*AW +: AW]),
      .rf_rdata_i   (rf_rdata_i[p*XLEN +: XLEN]),
      .stage_data_i (stage_data_i),
      .op_data_o    (op_data_o[p*XLEN +: XLEN]),
      .fwd_hit_o    (fwd_hit_o[p]),
      .not_ready_o  (not_ready[p])
    );
  end

  assign hazard_o   = dec_valid_i & ~dec_kill_i & (|(rs_used_i & not_ready));
  assign rf_we_o    = entry_q[NSTAGES-1].valid & entry_q[NSTAGES-1].wen & ~freeze_i;
  assign rf_waddr_o = entry_q[NSTAGES-1].waddr[AW-1:0];
  assign rf_wdata_o = stage_data_i[(NSTAGES-1)*XLEN +: XLEN];

endmodule
